// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU beside the EXE stage.
// Stalls the pipeline while iterating and returns {remainder, quotient}.
module div_seq #(
    parameter int DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 signed_div_i,
    input  logic [DIV_W-1:0]     opdata1_i,
    input  logic [DIV_W-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*DIV_W-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CW = $clog2(DIV_W) + 1;
    localparam logic [CW-1:0] CNT_END = CW'(DIV_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_DONE
    } state_t;

    state_t               r_state, w_state_n;
    logic [CW-1:0]        r_cnt, w_cnt_n;
    logic [2*DIV_W:0]     r_dreg, w_dreg_n;
    logic [DIV_W-1:0]     r_op2, w_op2_n;
    logic                 r_neg_q, w_neg_q_n;
    logic                 r_neg_r, w_neg_r_n;
    logic                 r_ready, w_ready_n;
    logic [2*DIV_W-1:0]   r_result, w_result_n;

    logic [DIV_W-1:0]     w_abs1, w_abs2;
    logic [DIV_W:0]       w_diff;
    logic [DIV_W-1:0]     w_quo, w_rem;

    assign w_abs1 = (signed_div_i && opdata1_i[DIV_W-1])
                  ? ({DIV_W{1'b0}} - opdata1_i) : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[DIV_W-1])
                  ? ({DIV_W{1'b0}} - opdata2_i) : opdata2_i;

    assign w_diff = {1'b0, r_dreg[2*DIV_W-1:DIV_W]} - {1'b0, r_op2};

    // Sign fix-up of the magnitudes; flags already include the signed mode.
    assign w_quo = r_neg_q ? ({DIV_W{1'b0}} - r_dreg[DIV_W-1:0])
                           : r_dreg[DIV_W-1:0];
    assign w_rem = r_neg_r ? ({DIV_W{1'b0}} - r_dreg[2*DIV_W:DIV_W+1])
                           : r_dreg[2*DIV_W:DIV_W+1];

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_dreg_n   = r_dreg;
        w_op2_n    = r_op2;
        w_neg_q_n  = r_neg_q;
        w_neg_r_n  = r_neg_r;
        w_ready_n  = r_ready;
        w_result_n = r_result;
        unique case (r_state)
            S_IDLE: begin
                w_ready_n  = 1'b0;
                w_result_n = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_n = S_BYZERO;
                    end else begin
                        w_state_n = S_ON;
                        w_cnt_n   = '0;
                        w_op2_n   = w_abs2;
                        w_dreg_n  = {{DIV_W{1'b0}}, w_abs1, 1'b0};
                        w_neg_r_n = signed_div_i & opdata1_i[DIV_W-1];
                        w_neg_q_n = signed_div_i &
                                    (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
                    end
                end
            end
            S_BYZERO: begin
                w_state_n  = S_DONE;
                w_result_n = '0;
                w_ready_n  = 1'b1;
            end
            S_ON: begin
                if (annul_i || !start_i) begin
                    w_state_n  = S_IDLE;
                    w_ready_n  = 1'b0;
                    w_result_n = '0;
                end else if (r_cnt != CNT_END) begin
                    w_cnt_n = r_cnt + 1'b1;
                    if (w_diff[DIV_W])
                        w_dreg_n = {r_dreg[2*DIV_W-1:0], 1'b0};
                    else
                        w_dreg_n = {w_diff[DIV_W-1:0],
                                    r_dreg[DIV_W-1:0], 1'b1};
                end else begin
                    w_state_n  = S_DONE;
                    w_ready_n  = 1'b1;
                    w_result_n = {w_rem, w_quo};
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    w_state_n  = S_IDLE;
                    w_ready_n  = 1'b0;
                    w_result_n = '0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dreg   <= '0;
            r_op2    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_dreg   <= w_dreg_n;
            r_op2    <= w_op2_n;
            r_neg_q  <= w_neg_q_n;
            r_neg_r  <= w_neg_r_n;
            r_ready  <= w_ready_n;
            r_result <= w_result_n;
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign stallreq_o = start_i & ~r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: driver pushes expected results and ready
// cycles into a queue, a negedge monitor pops them when ready_o rises.
module tb_div_seq;

    logic        clk;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    div_seq #(.DIV_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare on each rising edge of ready_o.
    always @(negedge clk) begin
        if (ready_o && !prev_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 64'(ready_o), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result_o, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_rdy = ready_o;
    end

    task automatic run(input bit s, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [63:0] res, input bit chg);
        exp_t e;
        int   stall;
        bit   got;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res = res;
        e.cyc = cyc + 1 + lat;
        q.push_back(e);
        stall = 0;
        got   = 1'b0;
        #1;
        if (stallreq_o) stall++;
        if (chg) begin
            @(posedge clk);
            #1;
            opdata1_i = ~a;
            opdata2_i = b + 32'd5;
            signed_div_i = ~s;
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            if (stallreq_o) stall++;
        end
        chk("ready_seen", 64'(got), 64'd1);
        chk("stall_cycles", 64'(stall), 64'(lat + 1));
        chk("stall_low_at_ready", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        chk("ready_held", 64'(ready_o), 64'd1);
        chk("result_held", result_o, res);
        start_i = 1'b0;
        @(negedge clk);
        chk("ready_drop", 64'(ready_o), 64'd0);
        chk("result_clear", result_o, 64'd0);
    endtask

    initial begin
        resetn       = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #3;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_stall", 64'(stallreq_o), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b0;

        run(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);
        run(1'b1, 32'hFFFFFFF9, 32'd2, 33,
            {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        run(1'b1, 32'd7, 32'hFFFFFFFE, 33,
            {32'd1, 32'hFFFFFFFD}, 1'b0);
        run(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33,
            {32'hFFFFFFFE, 32'd14}, 1'b0);
        run(1'b0, 32'hFFFFFFFF, 32'h10, 33,
            {32'hF, 32'h0FFFFFFF}, 1'b0);
        run(1'b0, 32'h1234, 32'd0, 1, 64'd0, 1'b0);

        // Annul at edge 10: no result expected.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        repeat (40) @(negedge clk);
        run(1'b0, 32'hFFFFFFFF, 32'd1, 33, {32'd0, 32'hFFFFFFFF}, 1'b0);

        // Async reset mid-division.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        resetn  = 1'b1;
        start_i = 1'b0;
        #1;
        chk("areset_ready", 64'(ready_o), 64'd0);
        chk("areset_result", result_o, 64'd0);
        chk("areset_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        resetn = 1'b0;
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 33,
            {32'd0, 32'h80000000}, 1'b0);

        // Operands and mode altered after edge 0.
        run(1'b0, 32'd1000, 32'd33, 33, {32'd10, 32'd30}, 1'b1);
        run(1'b1, 32'hFFFFFFF9, 32'd2, 33,
            {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
